// File: rtl/alu_pkg.sv
// ALU control encodings and default datapath widths shared by the ID/EX stage.
package alu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RA_W_DEF  = 5;
  localparam int CTL_W_DEF = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_ADDS = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SUBS = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLL  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SRA  = 4'b1110
  } alu_ctl_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register: MEM beats WB beats regfile.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            mem_wen,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] operand
);

  // x0 is never forwarded: whatever the regfile port supplies is used.
  always_comb begin
    operand = rf_val;
    if (rs != '0) begin
      if (mem_wen && mem_rd_addr == rs)     operand = mem_data;
      else if (wb_wen && wb_rd_addr == rs)  operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with MEM/WB forwarding, load-use stall and flush.
// Optional STAGE_PERF_CNT_EN adds saturating stall/bubble counters.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CTL_W = CTL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             id_use_imm,
  input  logic             id_use_pc,
  input  logic [CTL_W-1:0] id_alu_ctl,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_mem_rd,
  input  logic             flush,
  input  logic             mem_wen,
  input  logic [RA_W-1:0]  mem_rd_addr,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             wb_wen,
  input  logic [RA_W-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0]  wb_fwd_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_alu_da,
  output logic [XLEN-1:0]  ex_alu_db,
  output logic [CTL_W-1:0] ex_alu_ctl,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_mem_rd
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][RA_W-1:0] src_rs;
  logic [NUM_SRC-1:0][XLEN-1:0] src_val;
  logic [NUM_SRC-1:0][XLEN-1:0] src_fwd;

  assign src_rs  = {id_rs2, id_rs1};
  assign src_val = {id_rs2_val, id_rs1_val};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .rs          (src_rs[g]),
      .rf_val      (src_val[g]),
      .mem_wen     (mem_wen),
      .mem_rd_addr (mem_rd_addr),
      .mem_data    (mem_fwd_data),
      .wb_wen      (wb_wen),
      .wb_rd_addr  (wb_rd_addr),
      .wb_data     (wb_fwd_data),
      .operand     (src_fwd[g])
    );
  end

  logic             ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0]  ex_alu_da_q,  ex_alu_da_d;
  logic [XLEN-1:0]  ex_alu_db_q,  ex_alu_db_d;
  logic [CTL_W-1:0] ex_alu_ctl_q, ex_alu_ctl_d;
  logic [XLEN-1:0]  ex_rs2_val_q, ex_rs2_val_d;
  logic [RA_W-1:0]  ex_rd_q,      ex_rd_d;
  logic             ex_mem_rd_q,  ex_mem_rd_d;

  logic advance, hazard, capture;

  // A load in EX blocks any consumer; rs1 is irrelevant when operand A is the PC.
  assign advance  = !ex_valid_q || ex_ready;
  assign hazard   = ex_valid_q && ex_mem_rd_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1 && !id_use_pc) || ex_rd_q == id_rs2);
  assign id_ready = advance && !hazard && !flush;
  assign capture  = id_valid && id_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_alu_da_d  = ex_alu_da_q;
    ex_alu_db_d  = ex_alu_db_q;
    ex_alu_ctl_d = ex_alu_ctl_q;
    ex_rs2_val_d = ex_rs2_val_q;
    ex_rd_d      = ex_rd_q;
    ex_mem_rd_d  = ex_mem_rd_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d   = 1'b1;
      ex_alu_da_d  = id_use_pc  ? id_pc  : src_fwd[0];
      ex_alu_db_d  = id_use_imm ? id_imm : src_fwd[1];
      ex_alu_ctl_d = id_alu_ctl;
      ex_rs2_val_d = src_fwd[1];
      ex_rd_d      = id_rd;
      ex_mem_rd_d  = id_mem_rd;
    end else if (advance) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_alu_da_q  <= '0;
      ex_alu_db_q  <= '0;
      ex_alu_ctl_q <= CTL_W'(ALU_ADD);
      ex_rs2_val_q <= '0;
      ex_rd_q      <= '0;
      ex_mem_rd_q  <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_alu_da_q  <= ex_alu_da_d;
      ex_alu_db_q  <= ex_alu_db_d;
      ex_alu_ctl_q <= ex_alu_ctl_d;
      ex_rs2_val_q <= ex_rs2_val_d;
      ex_rd_q      <= ex_rd_d;
      ex_mem_rd_q  <= ex_mem_rd_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_alu_da  = ex_alu_da_q;
  assign ex_alu_db  = ex_alu_db_q;
  assign ex_alu_ctl = ex_alu_ctl_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_rd      = ex_rd_q;
  assign ex_mem_rd  = ex_mem_rd_q;

`ifdef STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_wr;

  // Every cycle that clears ex_valid without a capture writes a bubble.
  assign bubble_wr = flush || (advance && !capture);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (id_valid && !id_ready && !flush && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bubble_wr && bubble_cnt_q != '1)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: forwarding, load-use stall, back-pressure, flush, reset.
module tb_id_ex_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, id_pc;
  logic        id_use_imm, id_use_pc, id_mem_rd, flush;
  logic [3:0]  id_alu_ctl;
  logic        mem_wen, wb_wen;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        ex_valid, ex_ready, ex_mem_rd;
  logic [31:0] ex_alu_da, ex_alu_db, ex_rs2_val;
  logic [3:0]  ex_alu_ctl;
  logic [4:0]  ex_rd;
`ifdef STAGE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_pc(id_pc), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_alu_ctl(id_alu_ctl), .id_rd(id_rd), .id_mem_rd(id_mem_rd), .flush(flush),
    .mem_wen(mem_wen), .mem_rd_addr(mem_rd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_wen(wb_wen), .wb_rd_addr(wb_rd_addr), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_da(ex_alu_da), .ex_alu_db(ex_alu_db),
    .ex_alu_ctl(ex_alu_ctl), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd)
`ifdef STAGE_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  ctl;
    logic [31:0] rs2v;
    logic [4:0]  rd;
    logic        mr;
  } exp_t;

  exp_t sb[$];
  exp_t obs;
  int   checks = 0;
  int   failures = 0;

  always_comb obs = {ex_alu_da, ex_alu_db, ex_alu_ctl, ex_rs2_val, ex_rd, ex_mem_rd};

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_val = 0; id_rs2_val = 0;
    id_imm = 0; id_pc = 0; id_use_imm = 0; id_use_pc = 0; id_alu_ctl = 0;
    id_rd = 0; id_mem_rd = 0; flush = 0; ex_ready = 1;
    mem_wen = 0; mem_rd_addr = 0; mem_fwd_data = 0;
    wb_wen = 0; wb_rd_addr = 0; wb_fwd_data = 0;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [31:0] v1,
                       input logic [4:0] rs2, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic ui, input logic up, input logic [3:0] ctl,
                       input logic [4:0] rd, input logic mr);
    id_valid = 1; id_rs1 = rs1; id_rs1_val = v1; id_rs2 = rs2; id_rs2_val = v2;
    id_imm = imm; id_pc = pc; id_use_imm = ui; id_use_pc = up;
    id_alu_ctl = ctl; id_rd = rd; id_mem_rd = mr;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    checks++;
    if (ex_alu_ctl !== 4'b0000) begin failures++; $display("FAIL reset_ctl got %b exp 0000", ex_alu_ctl); end
    checks++;
    if (obs !== exp_t'(0)) begin failures++; $display("FAIL reset_data got %h exp 0", obs); end
    rst = 0;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", id_ready); end
  endtask

  // Back-to-back captures with ex_ready held high; each row is one instruction.
  task automatic test_forwarding();
    logic [4:0]  t_rs1 [5] = '{5'd1, 5'd3, 5'd0, 5'd8, 5'd8};
    logic [31:0] t_v1  [5] = '{32'd5, 32'd1, 32'h55, 32'd1, 32'd1};
    logic [4:0]  t_rs2 [5] = '{5'd2, 5'd3, 5'd7, 5'd9, 5'd0};
    logic [31:0] t_v2  [5] = '{32'd7, 32'd2, 32'd3, 32'd2, 32'h77};
    logic [31:0] t_imm [5] = '{32'd0, 32'd0, 32'd0, 32'h123, 32'd0};
    logic        t_ui  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_up  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t_mw  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0]  t_ma  [5] = '{5'd1, 5'd3, 5'd0, 5'd9, 5'd0};
    logic [31:0] t_md  [5] = '{32'd100, 32'd11, 32'd9, 32'd44, 32'd9};
    logic        t_ww  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  t_wa  [5] = '{5'd0, 5'd3, 5'd0, 5'd8, 5'd0};
    logic [31:0] t_wd  [5] = '{32'd0, 32'd22, 32'd8, 32'd22, 32'd0};
    logic [3:0]  t_ctl [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_SLT, ALU_SRA};
    logic [31:0] e_da  [5] = '{32'd100, 32'd11, 32'h55, 32'd22, 32'h400};
    logic [31:0] e_db  [5] = '{32'd7, 32'd11, 32'd3, 32'h123, 32'h77};
    logic [31:0] e_r2  [5] = '{32'd7, 32'd11, 32'd3, 32'd44, 32'h77};
    exp_t e;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = (sb.size() != 0) ? sb.pop_front() : 'x;
        checks++;
        if (ex_valid !== 1'b1 || obs !== e) begin
          failures++;
          $display("FAIL fwd[%0d] got valid=%b %h exp valid=1 %h", i - 1, ex_valid, obs, e);
        end
      end
      if (i < 5) begin
        offer(t_rs1[i], t_v1[i], t_rs2[i], t_v2[i], t_imm[i], 32'h400,
              t_ui[i], t_up[i], t_ctl[i], 5'(i + 5), 1'b0);
        mem_wen = t_mw[i]; mem_rd_addr = t_ma[i]; mem_fwd_data = t_md[i];
        wb_wen = t_ww[i];  wb_rd_addr = t_wa[i];  wb_fwd_data = t_wd[i];
        sb.push_back('{e_da[i], e_db[i], t_ctl[i], e_r2[i], 5'(i + 5), 1'b0});
        #1;
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL fwd_ready[%0d] got %b exp 1", i, id_ready); end
      end else begin
        set_idle();
      end
    end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL fwd_drain got %b exp 0", ex_valid); end
  endtask

  task automatic test_load_use();
    exp_t e;
`ifdef STAGE_PERF_CNT_EN
    logic [31:0] s0, b0;
`endif
    @(negedge clk);
    set_idle();
`ifdef STAGE_PERF_CNT_EN
    s0 = perf_stall_cnt; b0 = perf_bubble_cnt;
`endif
    offer(5'd1, 32'h10, 5'd0, 32'd0, 32'd4, 32'd0, 1'b1, 1'b0, ALU_ADD, 5'd4, 1'b1);
    sb.push_back('{32'h10, 32'd4, ALU_ADD, 32'd0, 5'd4, 1'b1});
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (ex_valid !== 1'b1 || obs !== e) begin failures++; $display("FAIL lu_load got %b %h exp 1 %h", ex_valid, obs, e); end
    offer(5'd4, 32'h99, 5'd2, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd5, 1'b0);
    #1;
    checks++;
    if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_hazard got %b exp 0", id_ready); end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got %b exp 0", ex_valid); end
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_release got %b exp 1", id_ready); end
    sb.push_back('{32'h99, 32'd7, ALU_ADD, 32'd7, 5'd5, 1'b0});
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (ex_valid !== 1'b1 || obs !== e) begin failures++; $display("FAIL lu_add got %b %h exp 1 %h", ex_valid, obs, e); end
`ifdef STAGE_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt - s0 !== 32'd1) begin failures++; $display("FAIL perf_stall got %0d exp 1", perf_stall_cnt - s0); end
    checks++;
    if (perf_bubble_cnt - b0 !== 32'd1) begin failures++; $display("FAIL perf_bubble got %0d exp 1", perf_bubble_cnt - b0); end
`endif
    // A load's rd matching rs1 is harmless when operand A is the PC.
    offer(5'd1, 32'h10, 5'd0, 32'd0, 32'd4, 32'd0, 1'b1, 1'b0, ALU_ADD, 5'd4, 1'b1);
    sb.push_back('{32'h10, 32'd4, ALU_ADD, 32'd0, 5'd4, 1'b1});
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (ex_valid !== 1'b1 || obs !== e) begin failures++; $display("FAIL lu_load2 got %b %h exp 1 %h", ex_valid, obs, e); end
    offer(5'd4, 32'h99, 5'd3, 32'd1, 32'd0, 32'h80, 1'b0, 1'b1, ALU_XOR, 5'd6, 1'b0);
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_pc_nohaz got %b exp 1", id_ready); end
    sb.push_back('{32'h80, 32'd1, ALU_XOR, 32'd1, 5'd6, 1'b0});
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (ex_valid !== 1'b1 || obs !== e) begin failures++; $display("FAIL lu_pc got %b %h exp 1 %h", ex_valid, obs, e); end
    set_idle();
  endtask

  task automatic test_stall_flush();
    exp_t e;
    @(negedge clk);
    set_idle();
    offer(5'd10, 32'hAA, 5'd11, 32'hBB, 32'd0, 32'd0, 1'b0, 1'b0, ALU_SUB, 5'd12, 1'b0);
    sb.push_back('{32'hAA, 32'hBB, ALU_SUB, 32'hBB, 5'd12, 1'b0});
    @(negedge clk);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++;
    if (ex_valid !== 1'b1 || obs !== e) begin failures++; $display("FAIL sf_capture got %b %h exp 1 %h", ex_valid, obs, e); end
    ex_ready = 0;
    offer(5'd13, 32'd1, 5'd14, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, ALU_OR, 5'd15, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ex_valid !== 1'b1 || obs !== e || id_ready !== 1'b0) begin
        failures++;
        $display("FAIL sf_hold[%0d] got v=%b r=%b %h exp v=1 r=0 %h", c, ex_valid, id_ready, obs, e);
      end
      @(negedge clk);
    end
    flush = 1;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin failures++; $display("FAIL sf_flush_ready got %b exp 0", id_ready); end
    @(negedge clk);
    flush = 0; id_valid = 0;
    checks++;
    if (ex_valid !== 1'b0 || obs !== e) begin failures++; $display("FAIL sf_flush got v=%b %h exp v=0 %h", ex_valid, obs, e); end
    ex_ready = 1;
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin failures++; $display("FAIL sf_dropped got %b exp 0", ex_valid); end
  endtask

  task automatic test_reset_midstall();
    @(negedge clk);
    set_idle();
    ex_ready = 0;
    offer(5'd1, 32'h10, 5'd0, 32'd0, 32'd4, 32'd0, 1'b1, 1'b0, ALU_SLT, 5'd4, 1'b1);
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b1 || ex_alu_ctl !== ALU_SLT) begin failures++; $display("FAIL rm_load got %b %b exp 1 1001", ex_valid, ex_alu_ctl); end
    offer(5'd4, 32'h99, 5'd2, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd5, 1'b0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (ex_valid !== 1'b0 || obs !== exp_t'(0)) begin failures++; $display("FAIL rm_reset got %b %h exp 0 0", ex_valid, obs); end
    #1;
    checks++;
    if (id_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got %b exp 1", id_ready); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_reset_midstall();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
